// File: rtl/traffic_sensor_conditioner_pkg.sv
// traffic_pkg: road bit ordering and default sizing shared with the traffic light controller.
package traffic_pkg;
  localparam int ROAD1_BIT = 1;
  localparam int ROAD2_BIT = 0;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_STUCK_CYCLES = 1000;
endpackage

// File: rtl/traffic_sensor_conditioner_sensor_lane.sv
// sensor_lane: one road's synchroniser, debouncer, request latch, arrival counter and stuck detector.
// Stuck detection is built only with TRAFFIC_SENSOR_STUCK_DET_EN defined; otherwise o_stuck is 0.
module sensor_lane
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W = 3,
  parameter int CNT_W = DEF_CNT_W,
  parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int STUCK_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_raw,
  input  logic             i_serve,
  output logic             o_req,
  output logic             o_db,
  output logic [CNT_W-1:0] o_arrivals,
  output logic             o_stuck
);
`ifdef TRAFFIC_SENSOR_STUCK_DET_EN
  localparam bit STUCK_EN = 1'b1;
`else
  localparam bit STUCK_EN = 1'b0;
`endif
  logic r_s1, r_s2, r_db, r_db_q, r_req, r_stuck;
  logic [DB_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_arr;
  logic [STUCK_W-1:0] r_stk_cnt;
  logic w_rise;
  assign w_rise = r_db & ~r_db_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_db <= 1'b0;
      r_db_q <= 1'b0;
      r_db_cnt <= '0;
      r_req <= 1'b0;
      r_arr <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_db) r_db_cnt <= '0;
      else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_db <= r_s2;
        r_db_cnt <= '0;
      end else r_db_cnt <= r_db_cnt + 1'b1;
      r_db_q <= r_db;
      r_req <= (i_serve | r_stuck) ? 1'b0 : (r_req | r_db);
      if (w_rise && !r_stuck && r_arr != '1) r_arr <= r_arr + 1'b1;
    end
  end
  // With the feature compiled out STUCK_EN holds these flops at zero, so they reduce away.
  always_ff @(posedge clk) begin
    if (reset || !STUCK_EN || !r_db) begin
      r_stk_cnt <= '0;
      r_stuck <= 1'b0;
    end else begin
      if (r_stk_cnt != '1) r_stk_cnt <= r_stk_cnt + 1'b1;
      if (r_stk_cnt == STUCK_W'(STUCK_CYCLES - 1)) r_stuck <= 1'b1;
    end
  end
  assign o_req = r_req;
  assign o_db = r_db;
  assign o_arrivals = r_arr;
  assign o_stuck = r_stuck;
endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: turns raw loop-detector inputs into the l1l2 request vector for the light controller.
// Optional stuck-sensor masking via TRAFFIC_SENSOR_STUCK_DET_EN.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W = 3,
  parameter int CNT_W = DEF_CNT_W,
  parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int STUCK_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       raw_sensor,
  input  logic [1:0]       serve,
  output logic [1:0]       l1l2,
  output logic [1:0]       debounced,
  output logic [CNT_W-1:0] arrivals1,
  output logic [CNT_W-1:0] arrivals2,
  output logic [1:0]       stuck
);
  sensor_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W), .CNT_W(CNT_W),
    .STUCK_CYCLES(STUCK_CYCLES), .STUCK_W(STUCK_W)
  ) u_road1 (
    .clk(clk), .reset(reset),
    .i_raw(raw_sensor[ROAD1_BIT]), .i_serve(serve[ROAD1_BIT]),
    .o_req(l1l2[ROAD1_BIT]), .o_db(debounced[ROAD1_BIT]),
    .o_arrivals(arrivals1), .o_stuck(stuck[ROAD1_BIT])
  );
  sensor_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W), .CNT_W(CNT_W),
    .STUCK_CYCLES(STUCK_CYCLES), .STUCK_W(STUCK_W)
  ) u_road2 (
    .clk(clk), .reset(reset),
    .i_raw(raw_sensor[ROAD2_BIT]), .i_serve(serve[ROAD2_BIT]),
    .o_req(l1l2[ROAD2_BIT]), .o_db(debounced[ROAD2_BIT]),
    .o_arrivals(arrivals2), .o_stuck(stuck[ROAD2_BIT])
  );
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner: directed tests for the sensor conditioner with hand-computed expectations.
module tb_traffic_sensor_conditioner;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] raw_sensor, serve, l1l2, debounced, stuck;
  logic [7:0] arrivals1, arrivals2;
  int checks = 0;
  int errors = 0;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4), .DB_W(3), .CNT_W(8), .STUCK_CYCLES(20), .STUCK_W(10)
  ) dut (
    .clk(clk), .reset(reset), .raw_sensor(raw_sensor), .serve(serve),
    .l1l2(l1l2), .debounced(debounced), .arrivals1(arrivals1),
    .arrivals2(arrivals2), .stuck(stuck)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    raw_sensor = 2'b00;
    serve = 2'b00;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    raw_sensor = 2'b11;
    serve = 2'b00;
    step(3);
    checks++;
    if (debounced !== 2'b00) begin errors++; $display("FAIL reset_debounced: got %b expected 00", debounced); end
    checks++;
    if (l1l2 !== 2'b00) begin errors++; $display("FAIL reset_l1l2: got %b expected 00", l1l2); end
    checks++;
    if (arrivals1 !== 8'd0 || arrivals2 !== 8'd0) begin errors++; $display("FAIL reset_arrivals: got %0d/%0d expected 0/0", arrivals1, arrivals2); end
    checks++;
    if (stuck !== 2'b00) begin errors++; $display("FAIL reset_stuck: got %b expected 00", stuck); end
  endtask

  task automatic test_latency();
    do_reset();
    raw_sensor = 2'b10;
    step(5);
    checks++;
    if (debounced !== 2'b00) begin errors++; $display("FAIL lat_db_edge5: got %b expected 00", debounced); end
    step(1);
    checks++;
    if (debounced !== 2'b10) begin errors++; $display("FAIL lat_db_edge6: got %b expected 10", debounced); end
    checks++;
    if (l1l2 !== 2'b00) begin errors++; $display("FAIL lat_l1l2_edge6: got %b expected 00", l1l2); end
    step(1);
    checks++;
    if (l1l2 !== 2'b10) begin errors++; $display("FAIL lat_l1l2_edge7: got %b expected 10", l1l2); end
    step(1);
    checks++;
    if (arrivals1 !== 8'd1 || arrivals2 !== 8'd0) begin errors++; $display("FAIL lat_arrivals: got %0d/%0d expected 1/0", arrivals1, arrivals2); end
  endtask

  task automatic test_glitch();
    do_reset();
    raw_sensor = 2'b01;
    step(3);
    raw_sensor = 2'b00;
    step(10);
    checks++;
    if (debounced !== 2'b00 || l1l2 !== 2'b00 || arrivals2 !== 8'd0) begin
      errors++; $display("FAIL glitch3: got db=%b l1l2=%b arr2=%0d expected 00/00/0", debounced, l1l2, arrivals2);
    end
    raw_sensor = 2'b01;
    step(4);
    raw_sensor = 2'b00;
    step(3);
    checks++;
    if (debounced !== 2'b01 || arrivals2 !== 8'd1) begin
      errors++; $display("FAIL pulse4: got db=%b arr2=%0d expected 01/1", debounced, arrivals2);
    end
  endtask

  task automatic test_latch();
    do_reset();
    raw_sensor = 2'b01;
    step(7);
    checks++;
    if (l1l2 !== 2'b01) begin errors++; $display("FAIL latch_set: got %b expected 01", l1l2); end
    raw_sensor = 2'b00;
    step(10);
    checks++;
    if (debounced !== 2'b00 || l1l2 !== 2'b01) begin errors++; $display("FAIL latch_hold: got db=%b l1l2=%b expected 00/01", debounced, l1l2); end
    serve = 2'b01;
    step(1);
    checks++;
    if (l1l2 !== 2'b00) begin errors++; $display("FAIL latch_serve: got %b expected 00", l1l2); end
    serve = 2'b00;
    step(3);
    checks++;
    if (l1l2 !== 2'b00) begin errors++; $display("FAIL latch_cleared: got %b expected 00", l1l2); end
  endtask

  task automatic test_serve_pulse();
    do_reset();
    raw_sensor = 2'b10;
    step(8);
    serve = 2'b10;
    step(1);
    checks++;
    if (l1l2 !== 2'b00) begin errors++; $display("FAIL serve_low: got %b expected 00", l1l2); end
    serve = 2'b00;
    step(1);
    checks++;
    if (l1l2 !== 2'b10) begin errors++; $display("FAIL serve_reassert: got %b expected 10", l1l2); end
    raw_sensor = 2'b11;
    step(8);
    serve = 2'b11;
    step(1);
    checks++;
    if (l1l2 !== 2'b00) begin errors++; $display("FAIL serve11_low: got %b expected 00", l1l2); end
    serve = 2'b00;
    step(1);
    checks++;
    if (l1l2 !== 2'b11) begin errors++; $display("FAIL serve11_reassert: got %b expected 11", l1l2); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      raw_sensor = 2'b10;
      step(6);
      raw_sensor = 2'b00;
      step(6);
      if (i == 99) begin
        checks++;
        if (arrivals1 !== 8'd100) begin errors++; $display("FAIL arr_100: got %0d expected 100", arrivals1); end
      end
    end
    checks++;
    if (arrivals1 !== 8'd255 || arrivals2 !== 8'd0) begin errors++; $display("FAIL arr_sat: got %0d/%0d expected 255/0", arrivals1, arrivals2); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    raw_sensor = 2'b10;
    step(7);
    reset = 1'b1;
    step(1);
    checks++;
    if (debounced !== 2'b00 || l1l2 !== 2'b00 || arrivals1 !== 8'd0) begin
      errors++; $display("FAIL midreset: got db=%b l1l2=%b arr1=%0d expected 00/00/0", debounced, l1l2, arrivals1);
    end
    reset = 1'b0;
    step(5);
    checks++;
    if (debounced !== 2'b00) begin errors++; $display("FAIL requal_edge5: got %b expected 00", debounced); end
    step(1);
    checks++;
    if (debounced !== 2'b10) begin errors++; $display("FAIL requal_edge6: got %b expected 10", debounced); end
  endtask

  task automatic test_stuck();
    do_reset();
    raw_sensor = 2'b10;
    step(40);
`ifdef TRAFFIC_SENSOR_STUCK_DET_EN
    checks++;
    if (stuck !== 2'b10 || l1l2 !== 2'b00) begin errors++; $display("FAIL stuck_set: got stuck=%b l1l2=%b expected 10/00", stuck, l1l2); end
    raw_sensor = 2'b00;
    step(7);
    checks++;
    if (stuck !== 2'b00 || debounced !== 2'b00) begin errors++; $display("FAIL stuck_clear: got stuck=%b db=%b expected 00/00", stuck, debounced); end
`else
    checks++;
    if (stuck !== 2'b00 || l1l2 !== 2'b10) begin errors++; $display("FAIL nostuck: got stuck=%b l1l2=%b expected 00/10", stuck, l1l2); end
    checks++;
    if (arrivals1 !== 8'd1) begin errors++; $display("FAIL nostuck_arr: got %0d expected 1", arrivals1); end
`endif
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_latch();
    test_serve_pulse();
    test_saturation();
    test_reset_mid();
    test_stuck();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
